// File: rtl/int_pkg.sv
// Shared types and constants for the I8259 acknowledge / IVT fetch responder.
// The optional NMI input is enabled by defining NMI_EN.
package int_pkg;

  localparam int unsigned ADDR_W          = 20;
  localparam int unsigned DATA_W          = 16;
  localparam int unsigned VEC_W           = 8;
  localparam int unsigned CNT_W           = 4;
  localparam int unsigned IVT_ENTRY_SHIFT = 2;

  localparam logic [VEC_W-1:0]  NMI_VEC   = 8'd2;
  localparam logic [ADDR_W-1:0] CS_OFFSET = 20'd2;

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    RD_IP,
    RD_CS,
    DONE
  } state_e;

  // Result handed to the core sequencer on completion
  typedef struct packed {
    logic [DATA_W-1:0] ip;
    logic [DATA_W-1:0] cs;
    logic [VEC_W-1:0]  vec;
    logic              hw;
  } svc_t;

  // IVT word address: base + vec*4 (+2 for the CS word), wrapping modulo 2^20
  function automatic logic [ADDR_W-1:0] ivt_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [VEC_W-1:0]  vec,
                                                 input logic              cs_word);
    logic [ADDR_W-1:0] off;
    off = ADDR_W'(vec) << IVT_ENTRY_SHIFT;
    return base + off + (cs_word ? CS_OFFSET : '0);
  endfunction

endpackage

// File: rtl/ivt_word_rd.sv
// Single 16-bit word read handshake: request raised the cycle after start,
// held until the acknowledge, read data presented alongside the completion strobe.
module ivt_word_rd
  import int_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_c,
  input  logic [ADDR_W-1:0] addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_ack,
  output logic              done_c,
  output logic [DATA_W-1:0] rd_data_c
);

  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    req_d  = req_q;
    addr_d = addr_q;
    if (req_q && mem_ack) begin
      req_d = 1'b0;
    end else if (start_c && !req_q) begin
      req_d  = 1'b1;
      addr_d = addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      req_q  <= req_d;
      addr_q <= addr_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_addr  = addr_q;
  assign done_c    = req_q & mem_ack;
  assign rd_data_c = mem_data;

endmodule

// File: rtl/int_ack_ctrl.sv
// CPU-side responder for the I8259: INTR/INT n acceptance, acknowledge handshake, IVT fetch.
// Define NMI_EN to add the edge-triggered iNMI input (priority: INT n > NMI > INTR).
module int_ack_ctrl
  import int_pkg::*;
#(
  parameter logic [ADDR_W-1:0] IVT_BASE = 20'h00000,
  parameter int unsigned       ACK_TO   = 15
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iINT,
  input  logic [VEC_W-1:0]  iINT_T,
  output logic              oIntAck,
  input  logic              iIF,
  input  logic              iBoundary,
  input  logic              iSwReq,
  input  logic [VEC_W-1:0]  iSwVec,
`ifdef NMI_EN
  input  logic              iNMI,
`endif
  output logic              oBusy,
  output logic              oDone,
  output logic [DATA_W-1:0] oNewIP,
  output logic [DATA_W-1:0] oNewCS,
  output logic [VEC_W-1:0]  oVec,
  output logic              oHwTaken,
  output logic              oAckTO,
  output logic              oMemReq,
  output logic [ADDR_W-1:0] oMemAddr,
  input  logic [DATA_W-1:0] iMemData,
  input  logic              iMemAck
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              int_ack_q, int_ack_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ack_to_q, ack_to_d;
  svc_t              svc_q, svc_d;

  logic              rd_start_c;
  logic              rd_done_c;
  logic [DATA_W-1:0] rd_data_c;
  logic [ADDR_W-1:0] rd_addr_c;

`ifdef NMI_EN
  logic              nmi_prev_q, nmi_prev_d;
  logic              nmi_pend_q, nmi_pend_d;
  logic              nmi_take_c;
`endif

  assign rd_addr_c = ivt_addr(IVT_BASE, svc_q.vec, state_q == RD_CS);

  // Next-state, acceptance priority and result capture
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    int_ack_d  = int_ack_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ack_to_d   = ack_to_q;
    svc_d      = svc_q;
    rd_start_c = 1'b0;
`ifdef NMI_EN
    nmi_take_c = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (iSwReq) begin
          svc_d.vec = iSwVec;
          svc_d.hw  = 1'b0;
          busy_d    = 1'b1;
          state_d   = RD_IP;
`ifdef NMI_EN
        end else if (iBoundary && nmi_pend_q) begin
          svc_d.vec  = NMI_VEC;
          svc_d.hw   = 1'b1;
          busy_d     = 1'b1;
          nmi_take_c = 1'b1;
          state_d    = RD_IP;
`endif
        end else if (iBoundary && iIF && iINT) begin
          svc_d.vec = iINT_T;
          svc_d.hw  = 1'b1;
          busy_d    = 1'b1;
          int_ack_d = 1'b1;
          cnt_d     = '0;
          state_d   = ACK;
        end
      end
      ACK: begin
        // A PIC that never drops INT still gets its latched vector serviced
        if (!iINT) begin
          int_ack_d = 1'b0;
          state_d   = RD_IP;
        end else if (cnt_q == CNT_W'(ACK_TO - 1)) begin
          ack_to_d  = 1'b1;
          int_ack_d = 1'b0;
          state_d   = RD_IP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD_IP: begin
        rd_start_c = !oMemReq;
        if (rd_done_c) begin
          svc_d.ip = rd_data_c;
          state_d  = RD_CS;
        end
      end
      RD_CS: begin
        rd_start_c = !oMemReq;
        if (rd_done_c) begin
          svc_d.cs = rd_data_c;
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef NMI_EN
  // Rising-edge capture; a new edge in the take cycle stays pending
  always_comb begin
    nmi_prev_d = iNMI;
    nmi_pend_d = (nmi_pend_q && !nmi_take_c) || (iNMI && !nmi_prev_q);
  end
`endif

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      int_ack_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_to_q   <= 1'b0;
      svc_q      <= '0;
`ifdef NMI_EN
      nmi_prev_q <= 1'b0;
      nmi_pend_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      int_ack_q  <= int_ack_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_to_q   <= ack_to_d;
      svc_q      <= svc_d;
`ifdef NMI_EN
      nmi_prev_q <= nmi_prev_d;
      nmi_pend_q <= nmi_pend_d;
`endif
    end
  end

  ivt_word_rd u_rd (
    .clk       (iClk),
    .rst_n     (iRst),
    .start_c   (rd_start_c),
    .addr      (rd_addr_c),
    .mem_req   (oMemReq),
    .mem_addr  (oMemAddr),
    .mem_data  (iMemData),
    .mem_ack   (iMemAck),
    .done_c    (rd_done_c),
    .rd_data_c (rd_data_c)
  );

  assign oIntAck  = int_ack_q;
  assign oBusy    = busy_q;
  assign oDone    = done_q;
  assign oNewIP   = svc_q.ip;
  assign oNewCS   = svc_q.cs;
  assign oVec     = svc_q.vec;
  assign oHwTaken = svc_q.hw;
  assign oAckTO   = ack_to_q;

endmodule
